// File: rtl/bsg_manycore_eva_to_npa_pipe.sv
// Translates a 32-bit endpoint virtual byte address into a network physical address (x, y, epa).
// The result sits in one registered stage with a valid/yumi handshake, and invalid addresses are counted.
module bsg_manycore_eva_to_npa_pipe #(
  parameter int addr_width_p                 = 28,
  parameter int x_cord_width_p               = 6,
  parameter int y_cord_width_p               = 6,
  parameter int num_tiles_x_p                = 4,
  parameter int num_tiles_y_p                = 4,
  parameter int start_x_cord_p               = 0,
  parameter int vcache_rows_p                = 2,
  parameter int vcache_block_size_in_words_p = 8,
  parameter int vcache_size_p                = 1024,
  parameter int epa_word_addr_width_p        = 12,
  parameter int host_x_cord_p                = 0,
  parameter int host_y_cord_p                = 1,
  parameter int invalid_count_width_p        = 16
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             v_i,
  input  logic [31:0]                      eva_i,
  input  logic [x_cord_width_p-1:0]        tgo_x_i,
  input  logic [y_cord_width_p-1:0]        tgo_y_i,
  input  logic                             dram_enable_i,
  output logic                             ready_o,
  output logic                             v_o,
  output logic [x_cord_width_p-1:0]        x_cord_o,
  output logic [y_cord_width_p-1:0]        y_cord_o,
  output logic [addr_width_p-1:0]          epa_o,
  output logic                             is_invalid_addr_o,
  input  logic                             yumi_i,
  output logic [invalid_count_width_p-1:0] invalid_count_o
);

  localparam int lg_block_lp  = $clog2(vcache_block_size_in_words_p);
  localparam int lg_x_lp      = $clog2(num_tiles_x_p);
  localparam int lg_bank_lp   = $clog2(num_tiles_x_p * vcache_rows_p);
  localparam int lg_vcache_lp = $clog2(vcache_size_p);
  localparam int e_lp         = epa_word_addr_width_p;

  typedef enum logic [1:0] {
    e_dram,
    e_global,
    e_tile_group,
    e_invalid
  } region_e;

  region_e                      w_region;
  logic [lg_bank_lp-1:0]        w_stripe_bank;
  logic [lg_bank_lp-1:0]        w_flat_bank;
  logic [addr_width_p-1:0]      w_stripe_epa;
  logic [x_cord_width_p-1:0]    w_x;
  logic [y_cord_width_p-1:0]    w_y;
  logic [addr_width_p-1:0]      w_epa;
  logic                         w_invalid;
  logic                         w_accept;
  logic                         w_unused;

  logic                             r_v;
  logic [x_cord_width_p-1:0]        r_x;
  logic [y_cord_width_p-1:0]        r_y;
  logic [addr_width_p-1:0]          r_epa;
  logic                             r_invalid;
  logic [invalid_count_width_p-1:0] r_invalid_count;

  // Cache banks are numbered across the top row first, then the bottom row (y = num_tiles_y_p+1).
  function automatic logic [x_cord_width_p-1:0] bank_x(input logic [lg_bank_lp-1:0] bank);
    return x_cord_width_p'(bank[lg_x_lp-1:0]) + x_cord_width_p'(start_x_cord_p);
  endfunction

  function automatic logic [y_cord_width_p-1:0] bank_y(input logic [lg_bank_lp-1:0] bank);
    if (vcache_rows_p == 2) return bank[lg_bank_lp-1] ? y_cord_width_p'(num_tiles_y_p + 1) : '0;
    else                    return y_cord_width_p'(num_tiles_y_p + 1);
  endfunction

  assign w_stripe_bank = lg_bank_lp'(eva_i[30:0] >> (2 + lg_block_lp));
  assign w_flat_bank   = eva_i[2+lg_vcache_lp +: lg_bank_lp];
  assign w_stripe_epa  = addr_width_p'(((eva_i[30:0] >> (2 + lg_block_lp + lg_bank_lp)) << lg_block_lp)
                                       | 31'(eva_i[2 +: lg_block_lp]));
  assign w_unused      = ^eva_i[1:0];

  always_comb begin
    if      (eva_i[31]) w_region = e_dram;
    else if (eva_i[30]) w_region = e_global;
    else if (eva_i[29]) w_region = e_tile_group;
    else                w_region = e_invalid;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_x       = '0;
    w_y       = '0;
    w_epa     = '0;
    w_invalid = 1'b0;
    unique case (w_region)
      e_dram: begin
        if (dram_enable_i) begin
          w_x   = bank_x(w_stripe_bank);
          w_y   = bank_y(w_stripe_bank);
          w_epa = w_stripe_epa;
        end else if (eva_i[30]) begin
          w_x   = x_cord_width_p'(host_x_cord_p);
          w_y   = y_cord_width_p'(host_y_cord_p);
          w_epa = {1'b1, eva_i[2 +: addr_width_p-1]};
        end else begin
          w_x   = bank_x(w_flat_bank);
          w_y   = bank_y(w_flat_bank);
          w_epa = addr_width_p'(eva_i[2 +: lg_vcache_lp]);
        end
      end
      e_global: begin
        w_x   = eva_i[2+e_lp +: x_cord_width_p] + x_cord_width_p'(start_x_cord_p);
        w_y   = eva_i[2+e_lp+x_cord_width_p +: y_cord_width_p];
        w_epa = addr_width_p'(eva_i[2 +: e_lp]);
      end
      e_tile_group: begin
        w_x   = eva_i[2+e_lp +: x_cord_width_p] + tgo_x_i + x_cord_width_p'(start_x_cord_p);
        w_y   = eva_i[2+e_lp+x_cord_width_p +: y_cord_width_p] + tgo_y_i;
        w_epa = addr_width_p'(eva_i[2 +: e_lp]);
      end
      default: w_invalid = 1'b1;
    endcase
  end

  assign ready_o  = ~r_v | yumi_i;
  assign w_accept = v_i & ready_o;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_v             <= 1'b0;
      r_x             <= '0;
      r_y             <= '0;
      r_epa           <= '0;
      r_invalid       <= 1'b0;
      r_invalid_count <= '0;
    end else begin
      if (w_accept) begin
        r_v       <= 1'b1;
        r_x       <= w_x;
        r_y       <= w_y;
        r_epa     <= w_epa;
        r_invalid <= w_invalid;
      end else if (yumi_i) begin
        r_v <= 1'b0;
      end
      if (w_accept && w_invalid && !(&r_invalid_count))
        r_invalid_count <= r_invalid_count + invalid_count_width_p'(1);
    end
  end

  assign v_o               = r_v;
  assign x_cord_o          = r_x;
  assign y_cord_o          = r_y;
  assign epa_o             = r_epa;
  assign is_invalid_addr_o = r_invalid;
  assign invalid_count_o   = r_invalid_count;

endmodule
